cfg_unlock_ctrl: RTL and testbench
==================================

Name: cfg_unlock_ctrl

Overview:
Upstream feeder of the secure config/data register path. It accepts host requests over a valid/ready interface and gates them behind a multi-byte unlock key. It drives the 3-bit cfg word {lock, we, re} and the 8-bit write-data word wd consumed by the downstream ctrl/secure_reg pair. Repeated key failures put it in permanent lockout until reset.

Parameters:
KEY_BYTES, 2, number of bytes in the unlock key (>=1)
KEY, 16'hA55A, unlock key, KEY_BYTES*8 bits; byte KEY_BYTES-1 (MSB) is sent first
MAX_FAIL, 3, failed unlock attempts before LOCKOUT (>=1)
TIMEOUT, 16, idle cycles in UNLOCKED before auto-relock (>=2; used only with optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request ready; transfer occurs when req_valid && req_ready
req_op  in  2  operation: 0 UNLOCK (key byte), 1 CFG write, 2 DATA write, 3 LOCK
req_data  in  8  key byte, cfg value (bits [2:0]) or write data
resp_valid  out  1  one-cycle response pulse
resp_err  out  1  error flag; qualified by resp_valid
cfg  out  3  config word to downstream ctrl
wd  out  8  write data to downstream ctrl
unlocked  out  1  high while the state is UNLOCKED
lockout  out  1  high while the state is LOCKOUT
fail_cnt  out  $clog2(MAX_FAIL+1)  saturating count of failed attempts

Behaviour:
- Single clock, clk. rst is synchronous and active-high. Reset values: state LOCKED; cfg=0, wd=0, fail_cnt=0, resp_valid=0, resp_err=0, unlocked=0, lockout=0; key index=0; mismatch flag=0. rst overrides everything, including mid-key-sequence; a partial sequence is discarded and not counted as a failure.
- Handshake: one outstanding request. req_ready = !resp_valid. resp_valid pulses exactly 1 cycle after the transfer cycle, so the maximum rate is one request per 2 cycles. resp_err is registered alongside resp_valid and is 0 when resp_valid=0.
- States: LOCKED, KEY_COLLECT, UNLOCKED, LOCKOUT.
- LOCKED, UNLOCK op:
  - Compare req_data with the MSB key byte and set mismatch if unequal.
  - If KEY_BYTES==1, finalize immediately.
  - Otherwise go to KEY_COLLECT with index=1 and respond err=0.
- LOCKED, other ops: respond err=1, no state change.
- KEY_COLLECT, UNLOCK op: compare the next key byte and OR any mismatch into the flag. Intermediate bytes always respond err=0, with no early mismatch indication (every attempt consumes all KEY_BYTES bytes).
- Final key byte, finalize:
  - Mismatch flag clear: go to UNLOCKED, fail_cnt<=0, err=0.
  - Otherwise: fail_cnt<=fail_cnt+1 (saturating), err=1. Go to LOCKOUT if the new count equals MAX_FAIL, else go to LOCKED.
- KEY_COLLECT, non-UNLOCK op: abort. Counts as a failure with the same fail_cnt/LOCKOUT rule, err=1.
- UNLOCKED:
  - CFG op: cfg<=req_data[2:0], err=0.
  - DATA op: wd<=req_data, err=0.
  - LOCK op: go to LOCKED, err=0.
  - UNLOCK op: err=1, stay in UNLOCKED.
  - cfg and wd update in the transfer cycle and are visible on the next cycle.
- LOCKED/KEY_COLLECT/LOCKOUT: cfg and wd hold their last values; no op modifies them.
- LOCKOUT: every request is accepted and responds err=1. Only rst exits.
- unlocked and lockout are registered state decodes.

Optional Feature:
CFG_UNLOCK_TIMEOUT_EN
- Defined: an idle counter runs in UNLOCKED.
  - It reloads to 0 on every transfer and on entry to UNLOCKED.
  - When it reaches TIMEOUT-1 without a transfer, the state goes to LOCKED on the next edge; no response is generated.
  - A transfer in that same cycle takes priority: it is processed and the counter reloads.
- Undefined: no counter; UNLOCKED persists until a LOCK op or rst.

Decomposition:
- Package cfg_unlock_pkg:
  - op enum (OP_UNLOCK=0, OP_CFG=1, OP_DATA=2, OP_LOCK=3)
  - state enum (ST_LOCKED, ST_KEY_COLLECT, ST_UNLOCKED, ST_LOCKOUT)
  - cfg bit-index constants: CFG_RE=0, CFG_WE=1, CFG_LOCK=2
- One sub-module, unlock_idle_timer: counter, reload input, expire output. It is instantiated only under CFG_UNLOCK_TIMEOUT_EN.

Test Plan:
- Correct unlock and config: UNLOCK A5, UNLOCK 5A, CFG 8'h03, DATA 8'h3C -> err 0,0,0,0; unlocked=1; cfg=3'b011; wd=8'h3C.
- Wrong key: UNLOCK A5, UNLOCK 00 -> first resp err=0, second err=1; fail_cnt=1; state LOCKED; cfg/wd unchanged.
- Lockout: three wrong 2-byte attempts -> lockout=1, fail_cnt=3. Then the correct key A5,5A -> both err=1. rst -> lockout=0, fail_cnt=0.
- Abort mid-key: UNLOCK A5, then CFG 8'h07 -> err=1, fail_cnt=1, cfg stays 0. CFG op while LOCKED -> err=1.
- Handshake/reset: hold req_valid=1 for 6 cycles -> req_ready toggles 1,0,1,0..., exactly 3 transfers. Assert rst after the first key byte -> everything returns to reset values, fail_cnt=0.
- With CFG_UNLOCK_TIMEOUT_EN, TIMEOUT=16: unlock, then idle 16 cycles -> unlocked=0. A transfer on cycle 15 keeps it unlocked.

Source files
------------

// File: rtl/cfg_unlock_pkg.sv
// cfg_unlock_pkg: shared opcode/state encodings and cfg bit positions
// for the cfg_unlock_ctrl front end.
package cfg_unlock_pkg;

   localparam int unsigned OP_W   = 2;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CFG_W  = 3;

   // Bit positions inside the {lock, we, re} cfg word
   localparam int unsigned CFG_RE   = 0;
   localparam int unsigned CFG_WE   = 1;
   localparam int unsigned CFG_LOCK = 2;

   typedef enum logic [OP_W-1:0] {
      OP_UNLOCK = 2'd0,
      OP_CFG    = 2'd1,
      OP_DATA   = 2'd2,
      OP_LOCK   = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_LOCKED      = 2'd0,
      ST_KEY_COLLECT = 2'd1,
      ST_UNLOCKED    = 2'd2,
      ST_LOCKOUT     = 2'd3
   } state_e;

endpackage

// File: rtl/unlock_idle_timer.sv
// unlock_idle_timer: idle counter that saturates at TIMEOUT-1 and flags expiry.
// Used by cfg_unlock_ctrl only when CFG_UNLOCK_TIMEOUT_EN is defined.
module unlock_idle_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic reload,
   output logic expire
);

   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] cnt;

   // Count idle cycles, holding at the terminal value until reloaded
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (reload) begin
         cnt <= '0;
      end else if (cnt != CNT_W'(TIMEOUT - 1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expire = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cfg_unlock_ctrl.sv
// cfg_unlock_ctrl: key-gated request front end driving the {lock,we,re} cfg
// word and write data of the secure register path.
// Optional macro CFG_UNLOCK_TIMEOUT_EN: auto-relock after TIMEOUT idle cycles.
module cfg_unlock_ctrl
   import cfg_unlock_pkg::*;
#(
   parameter int unsigned           KEY_BYTES = 2,
   parameter logic [KEY_BYTES*8-1:0] KEY      = 16'hA55A,
   parameter int unsigned           MAX_FAIL  = 3,
   parameter int unsigned           TIMEOUT   = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic [OP_W-1:0]                 req_op,
   input  logic [DATA_W-1:0]               req_data,
   output logic                            resp_valid,
   output logic                            resp_err,
   output logic [CFG_W-1:0]                cfg,
   output logic [DATA_W-1:0]               wd,
   output logic                            unlocked,
   output logic                            lockout,
   output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

   localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
   localparam int unsigned IDX_W  = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam int unsigned KEY_W  = KEY_BYTES * 8;

   if (KEY_BYTES < 1 || MAX_FAIL < 1 || TIMEOUT < 2) begin : g_param_chk
      $error("cfg_unlock_ctrl: illegal parameter value");
   end

   state_e              state, state_nx;
   logic [IDX_W-1:0]    idx, idx_nx;
   logic                mis, mis_nx;
   logic [CFG_W-1:0]    cfg_nx;
   logic [DATA_W-1:0]   wd_nx;
   logic [FAIL_W-1:0]   fail_nx, fail_inc;
   logic                resp_valid_nx, resp_err_nx;
   logic                fail_ev, key_bad, last_byte, xfer;
   logic [KEY_W-1:0]    key_shift;
   logic [DATA_W-1:0]   key_byte;
   op_e                 op;

   assign req_ready = !resp_valid;
   assign xfer      = req_valid && req_ready;
   assign op        = op_e'(req_op);

   // Expected key byte for the current index, MSB byte first
   assign key_shift = KEY >> (8 * (KEY_BYTES - 1 - 32'(idx)));
   assign key_byte  = key_shift[DATA_W-1:0];
   assign last_byte = (idx == IDX_W'(KEY_BYTES - 1));
   assign key_bad   = mis || (req_data != key_byte);
   assign fail_inc  = (fail_cnt == FAIL_W'(MAX_FAIL)) ? fail_cnt : fail_cnt + FAIL_W'(1);

`ifdef CFG_UNLOCK_TIMEOUT_EN
   logic timer_expire;

   unlock_idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .clk    (clk),
      .rst    (rst),
      .reload (xfer || (state != ST_UNLOCKED)),
      .expire (timer_expire)
   );
`endif

   // Next-state and registered-output decode
   always_comb begin
      state_nx      = state;
      idx_nx        = idx;
      mis_nx        = mis;
      cfg_nx        = cfg;
      wd_nx         = wd;
      fail_nx       = fail_cnt;
      resp_valid_nx = 1'b0;
      resp_err_nx   = 1'b0;
      fail_ev       = 1'b0;

      if (xfer) begin
         resp_valid_nx = 1'b1;
         case (state)
            ST_LOCKED, ST_KEY_COLLECT: begin
               if (op == OP_UNLOCK) begin
                  if (last_byte) begin
                     idx_nx = '0;
                     mis_nx = 1'b0;
                     if (key_bad) begin
                        fail_ev = 1'b1;
                     end else begin
                        state_nx = ST_UNLOCKED;
                        fail_nx  = '0;
                     end
                  end else begin
                     state_nx = ST_KEY_COLLECT;
                     idx_nx   = idx + IDX_W'(1);
                     mis_nx   = key_bad;
                  end
               end else if (state == ST_KEY_COLLECT) begin
                  fail_ev = 1'b1;
               end else begin
                  resp_err_nx = 1'b1;
               end
            end
            ST_UNLOCKED: begin
               case (op)
                  OP_CFG:  cfg_nx = {req_data[CFG_LOCK], req_data[CFG_WE], req_data[CFG_RE]};
                  OP_DATA: wd_nx = req_data;
                  OP_LOCK: state_nx = ST_LOCKED;
                  default: resp_err_nx = 1'b1;
               endcase
            end
            default: resp_err_nx = 1'b1;
         endcase
      end
`ifdef CFG_UNLOCK_TIMEOUT_EN
      else if ((state == ST_UNLOCKED) && timer_expire) begin
         state_nx = ST_LOCKED;
      end
`endif

      // Failed attempt or aborted sequence
      if (fail_ev) begin
         resp_err_nx = 1'b1;
         fail_nx     = fail_inc;
         idx_nx      = '0;
         mis_nx      = 1'b0;
         state_nx    = (fail_inc == FAIL_W'(MAX_FAIL)) ? ST_LOCKOUT : ST_LOCKED;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_LOCKED;
         idx        <= '0;
         mis        <= 1'b0;
         cfg        <= '0;
         wd         <= '0;
         fail_cnt   <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         unlocked   <= 1'b0;
         lockout    <= 1'b0;
      end else begin
         state      <= state_nx;
         idx        <= idx_nx;
         mis        <= mis_nx;
         cfg        <= cfg_nx;
         wd         <= wd_nx;
         fail_cnt   <= fail_nx;
         resp_valid <= resp_valid_nx;
         resp_err   <= resp_err_nx;
         unlocked   <= (state_nx == ST_UNLOCKED);
         lockout    <= (state_nx == ST_LOCKOUT);
      end
   end

endmodule

// File: tb/tb_cfg_unlock_ctrl.sv
// tb_cfg_unlock_ctrl: scoreboard bench for cfg_unlock_ctrl (default parameters).
// Exercises the CFG_UNLOCK_TIMEOUT_EN path when that macro is defined.
module tb_cfg_unlock_ctrl;
   import cfg_unlock_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_op = 2'd0;
   logic [7:0] req_data = 8'd0;
   logic       resp_valid, resp_err, unlocked, lockout;
   logic [2:0] cfg;
   logic [7:0] wd;
   logic [1:0] fail_cnt;

   int   checks = 0;
   int   errors = 0;
   logic exp_q[$];

   cfg_unlock_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_data   (req_data),
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .cfg        (cfg),
      .wd         (wd),
      .unlocked   (unlocked),
      .lockout    (lockout),
      .fail_cnt   (fail_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Response monitor: pop the expected error flag for every response pulse
   always @(negedge clk) begin
      if (!rst) begin
         if (resp_valid) begin
            if (exp_q.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
            else check("resp_err", 32'(resp_err), 32'(exp_q.pop_front()));
         end else if (resp_err) begin
            check("resp_err_idle", 32'(resp_err), 32'd0);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input op_e op, input logic [7:0] d, input logic e);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check("ready_timeout", 32'(req_ready), 32'd1);
         return;
      end
      req_valid = 1'b1;
      req_op    = 2'(op);
      req_data  = d;
      exp_q.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   task automatic check_regs(input string tag, input logic [2:0] c, input logic [7:0] w,
                             input logic [1:0] f, input logic u, input logic l);
      check({tag, "_cfg"}, 32'(cfg), 32'(c));
      check({tag, "_wd"}, 32'(wd), 32'(w));
      check({tag, "_fail"}, 32'(fail_cnt), 32'(f));
      check({tag, "_unlocked"}, 32'(unlocked), 32'(u));
      check({tag, "_lockout"}, 32'(lockout), 32'(l));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit");
      $fatal(1);
   end

   initial begin
      int xfers;
      idle(2);
      rst = 1'b0;
      @(negedge clk);
      check_regs("reset", 3'd0, 8'h00, 2'd0, 1'b0, 1'b0);
      check("reset_resp_valid", 32'(resp_valid), 32'd0);
      check("reset_ready", 32'(req_ready), 32'd1);

      // Correct unlock and configuration
      send(OP_UNLOCK, 8'hA5, 1'b0);
      send(OP_UNLOCK, 8'h5A, 1'b0);
      idle(1);
      check("unlock_state", 32'(unlocked), 32'd1);
      send(OP_CFG, 8'h03, 1'b0);
      send(OP_DATA, 8'h3C, 1'b0);
      send(OP_UNLOCK, 8'hA5, 1'b1);
      idle(1);
      check_regs("unlocked", 3'b011, 8'h3C, 2'd0, 1'b1, 1'b0);
      send(OP_LOCK, 8'h00, 1'b0);
      idle(1);
      check_regs("relocked", 3'b011, 8'h3C, 2'd0, 1'b0, 1'b0);

      // Wrong key, then a CFG attempt while locked
      send(OP_UNLOCK, 8'hA5, 1'b0);
      send(OP_UNLOCK, 8'h00, 1'b1);
      send(OP_CFG, 8'h07, 1'b1);
      idle(1);
      check_regs("wrong_key", 3'b011, 8'h3C, 2'd1, 1'b0, 1'b0);

      // Two more failures reach lockout; correct key then rejected
      send(OP_UNLOCK, 8'h00, 1'b0);
      send(OP_UNLOCK, 8'h00, 1'b1);
      idle(1);
      check_regs("fail2", 3'b011, 8'h3C, 2'd2, 1'b0, 1'b0);
      send(OP_UNLOCK, 8'h11, 1'b0);
      send(OP_UNLOCK, 8'h5A, 1'b1);
      idle(1);
      check_regs("lockout", 3'b011, 8'h3C, 2'd3, 1'b0, 1'b1);
      send(OP_UNLOCK, 8'hA5, 1'b1);
      send(OP_UNLOCK, 8'h5A, 1'b1);
      send(OP_DATA, 8'hFF, 1'b1);
      idle(1);
      check_regs("lockout_hold", 3'b011, 8'h3C, 2'd3, 1'b0, 1'b1);
      idle(2);
      do_reset();
      @(negedge clk);
      check_regs("post_reset", 3'd0, 8'h00, 2'd0, 1'b0, 1'b0);

      // Abort mid-key counts as a failure
      send(OP_UNLOCK, 8'hA5, 1'b0);
      send(OP_CFG, 8'h07, 1'b1);
      idle(1);
      check_regs("abort", 3'd0, 8'h00, 2'd1, 1'b0, 1'b0);
      send(OP_UNLOCK, 8'hA5, 1'b0);
      send(OP_UNLOCK, 8'h5A, 1'b0);
      idle(1);
      check_regs("unlock_clears", 3'd0, 8'h00, 2'd0, 1'b1, 1'b0);
      send(OP_LOCK, 8'h00, 1'b0);

      // Reset mid-sequence discards the partial key and the fail count
      send(OP_UNLOCK, 8'h12, 1'b0);
      send(OP_UNLOCK, 8'h34, 1'b1);
      send(OP_UNLOCK, 8'hA5, 1'b0);
      idle(2);
      do_reset();
      @(negedge clk);
      check_regs("midkey_reset", 3'd0, 8'h00, 2'd0, 1'b0, 1'b0);
      send(OP_UNLOCK, 8'hA5, 1'b0);
      send(OP_UNLOCK, 8'h5A, 1'b0);
      idle(1);
      check_regs("after_reset_unlock", 3'd0, 8'h00, 2'd0, 1'b1, 1'b0);
      send(OP_LOCK, 8'h00, 1'b0);
      idle(2);

      // Held valid: ready alternates and only every other cycle transfers
      xfers = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_op    = 2'(OP_CFG);
         req_data  = 8'h01;
         check("ready_seq", 32'(req_ready), 32'((i % 2) == 0));
         if (req_ready) begin
            xfers++;
            exp_q.push_back(1'b1);
         end
      end
      @(negedge clk);
      req_valid = 1'b0;
      check("xfer_count", 32'(xfers), 32'd3);
      idle(2);
      check_regs("after_burst", 3'd0, 8'h00, 2'd0, 1'b0, 1'b0);

      // Idle behaviour while unlocked
      send(OP_UNLOCK, 8'hA5, 1'b0);
      send(OP_UNLOCK, 8'h5A, 1'b0);
`ifdef CFG_UNLOCK_TIMEOUT_EN
      idle(10);
      check("to_early", 32'(unlocked), 32'd1);
      send(OP_DATA, 8'h66, 1'b0);
      idle(12);
      check("to_reloaded", 32'(unlocked), 32'd1);
      idle(10);
      check("to_expired", 32'(unlocked), 32'd0);
      check("to_wd", 32'(wd), 32'h66);
`else
      idle(40);
      check("no_timeout", 32'(unlocked), 32'd1);
`endif

      idle(3);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
